// File: rtl/uart_receiver_pkg.sv
// Shared constants and state encoding for the UART receive path.
// Imported by the receiver and by anything that needs the same framing constants.
package uart_receiver_pkg;

   localparam int OVERSAMPLING_8  = 8;
   localparam int OVERSAMPLING_16 = 16;
   localparam int DATA_WIDTH      = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_DATA  = 2'b10,
      ST_STOP  = 2'b11
   } rx_state_t;

endpackage

// File: rtl/uart_receiver_input_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to all ones so an
// idle-high line never looks like activity while reset is released.
module input_synchronizer #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver driven by an oversampling tick strobe from the baud generator.
// Delivers each byte with a one-cycle done strobe and a framing-error flag.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int OVERSAMPLING = OVERSAMPLING_16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_rx_en,
   input  logic                  i_rx_tick,
   input  logic                  i_in,
   output logic [DATA_WIDTH-1:0] o_out,
   output logic                  o_done,
   output logic                  o_err,
   output logic                  o_busy
);

   localparam int TW = $clog2(OVERSAMPLING);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);

   rx_state_t             r_state;
   rx_state_t             w_state_next;
   logic [TW-1:0]         r_tick_cnt;
   logic [TW-1:0]         w_tick_next;
   logic [2:0]            r_bit_cnt;
   logic [2:0]            w_bit_next;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic                  r_armed;
   logic                  w_armed_next;
   logic [DATA_WIDTH-1:0] r_out;
   logic [DATA_WIDTH-1:0] w_out_next;
   logic                  r_err;
   logic                  w_err_next;
   logic                  r_done;
   logic                  w_done_next;
   logic                  w_in_sync;

   input_synchronizer #(
      .WIDTH (1)
   ) u_in_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_in),
      .o_q     (w_in_sync)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_tick_next  = r_tick_cnt;
      w_bit_next   = r_bit_cnt;
      w_shift_next = r_shift;
      w_armed_next = r_armed;
      w_out_next   = r_out;
      w_err_next   = r_err;
      w_done_next  = 1'b0;

      if (!i_rx_en) begin
         w_state_next = ST_IDLE;
         w_tick_next  = '0;
         w_bit_next   = '0;
         w_armed_next = 1'b0;
      end else if (i_rx_tick) begin
         case (r_state)
            ST_IDLE: begin
               // A start is only accepted after the line was seen high, so a
               // held-low break cannot retrigger frames.
               if (w_in_sync) begin
                  w_armed_next = 1'b1;
               end else if (r_armed) begin
                  w_state_next = ST_START;
                  w_tick_next  = '0;
                  w_armed_next = 1'b0;
               end
            end
            ST_START: begin
               if (r_tick_cnt == TICK_MID) begin
                  w_tick_next  = '0;
                  w_bit_next   = '0;
                  w_state_next = w_in_sync ? ST_IDLE : ST_DATA;
               end else begin
                  w_tick_next = r_tick_cnt + TW'(1);
               end
            end
            ST_DATA: begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_next  = '0;
                  w_shift_next = {w_in_sync, r_shift[DATA_WIDTH-1:1]};
                  w_bit_next   = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     w_state_next = ST_STOP;
                  end
               end else begin
                  w_tick_next = r_tick_cnt + TW'(1);
               end
            end
            ST_STOP: begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_next  = '0;
                  w_out_next   = r_shift;
                  w_err_next   = ~w_in_sync;
                  w_done_next  = 1'b1;
                  w_state_next = ST_IDLE;
                  // A high stop bit arms IDLE so back-to-back frames need no idle bit.
                  w_armed_next = w_in_sync;
               end else begin
                  w_tick_next = r_tick_cnt + TW'(1);
               end
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_armed    <= 1'b0;
         r_out      <= '0;
         r_err      <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_tick_cnt <= w_tick_next;
         r_bit_cnt  <= w_bit_next;
         r_shift    <= w_shift_next;
         r_armed    <= w_armed_next;
         r_out      <= w_out_next;
         r_err      <= w_err_next;
         r_done     <= w_done_next;
      end
   end

   assign o_out  = r_out;
   assign o_done = r_done;
   assign o_err  = r_err;
   assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OS=16, tick every 54 clk, 868 clk per line bit.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_receiver;

   localparam int BIT_CLKS  = 868;
   localparam int HALF_BIT  = 434;
   localparam int TICK_CLKS = 54;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_en = 1'b0;
   logic       rx_tick = 1'b0;
   logic       line = 1'b1;
   logic [7:0] out;
   logic       done;
   logic       err;
   logic       busy;

   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   logic prev_done = 1'b0;
   logic dbl_done = 1'b0;
   logic busy_all;
   int   base;

   uart_receiver #(
      .OVERSAMPLING (16)
   ) dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_rx_en   (rx_en),
      .i_rx_tick (rx_tick),
      .i_in      (line),
      .o_out     (out),
      .o_done    (done),
      .o_err     (err),
      .o_busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (TICK_CLKS - 1) @(negedge clk);
         rx_tick = 1'b1;
         @(negedge clk);
         rx_tick = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (done) begin
         done_cnt = done_cnt + 1;
         if (prev_done) dbl_done = 1'b1;
         $display("[%0t] rx byte 0x%02h err=%0b", $time, out, err);
      end
      prev_done = done;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one full frame; busy_all records busy at every start/data bit midpoint.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      busy_all = 1'b1;
      line = 1'b0;
      wait_clks(HALF_BIT);
      busy_all = busy_all & busy;
      wait_clks(BIT_CLKS - HALF_BIT);
      for (int i = 0; i < 8; i++) begin
         line = data[i];
         wait_clks(HALF_BIT);
         busy_all = busy_all & busy;
         wait_clks(BIT_CLKS - HALF_BIT);
      end
      line = stop_bit;
      wait_clks(BIT_CLKS);
   endtask

   initial begin
      // Reset state
      wait_clks(3);
      check("reset_out", 32'(out), 32'h00);
      check("reset_done", 32'(done), 32'h0);
      check("reset_err", 32'(err), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      rx_en = 1'b1;
      wait_clks(1000);

      // 0xA5 with valid stop bit
      base = done_cnt;
      send_frame(8'hA5, 1'b1);
      check("a5_done_cnt", 32'(done_cnt - base), 32'd1);
      check("a5_out", 32'(out), 32'hA5);
      check("a5_err", 32'(err), 32'h0);
      check("a5_busy_frame", 32'(busy_all), 32'h1);
      check("a5_busy_after", 32'(busy), 32'h0);

      // 0x00 then 0xFF back-to-back, no idle bit
      base = done_cnt;
      send_frame(8'h00, 1'b1);
      check("b2b0_done_cnt", 32'(done_cnt - base), 32'd1);
      check("b2b0_out", 32'(out), 32'h00);
      check("b2b0_err", 32'(err), 32'h0);
      send_frame(8'hFF, 1'b1);
      check("b2b1_done_cnt", 32'(done_cnt - base), 32'd2);
      check("b2b1_out", 32'(out), 32'hFF);
      check("b2b1_err", 32'(err), 32'h0);
      wait_clks(1000);

      // Low glitch of 5 ticks: false start
      base = done_cnt;
      line = 1'b0;
      wait_clks(200);
      check("glitch_busy_high", 32'(busy), 32'h1);
      wait_clks(5 * TICK_CLKS - 200);
      line = 1'b1;
      wait_clks(1000);
      check("glitch_no_done", 32'(done_cnt - base), 32'd0);
      check("glitch_busy_low", 32'(busy), 32'h0);
      check("glitch_out_hold", 32'(out), 32'hFF);

      // 0x3C with low stop bit, then a 3-bit break
      base = done_cnt;
      send_frame(8'h3C, 1'b0);
      wait_clks(3 * BIT_CLKS);
      check("break_done_cnt", 32'(done_cnt - base), 32'd1);
      check("break_out", 32'(out), 32'h3C);
      check("break_err", 32'(err), 32'h1);
      check("break_busy", 32'(busy), 32'h0);
      line = 1'b1;
      wait_clks(1000);
      check("break_no_retrigger", 32'(done_cnt - base), 32'd1);

      // Reset during data bit 4, then 0x55
      base = done_cnt;
      line = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         line = 1'(8'h96 >> i);
         wait_clks(BIT_CLKS);
      end
      line = 1'b1;
      wait_clks(HALF_BIT);
      check("rst_busy_before", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      check("rst_mid_out", 32'(out), 32'h00);
      check("rst_mid_err", 32'(err), 32'h0);
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_done", 32'(done), 32'h0);
      wait_clks(3);
      reset = 1'b0;
      wait_clks(1000);
      check("rst_no_done", 32'(done_cnt - base), 32'd0);
      send_frame(8'h55, 1'b1);
      check("rst_55_done_cnt", 32'(done_cnt - base), 32'd1);
      check("rst_55_out", 32'(out), 32'h55);
      check("rst_55_err", 32'(err), 32'h0);

      // rxEn dropped during data bit 2 for 10 ticks, then 0xAA
      base = done_cnt;
      line = 1'b0;
      wait_clks(BIT_CLKS);
      line = 1'b1;
      wait_clks(BIT_CLKS);
      line = 1'b0;
      wait_clks(BIT_CLKS);
      line = 1'b0;
      wait_clks(HALF_BIT);
      rx_en = 1'b0;
      wait_clks(2);
      check("en_busy_low", 32'(busy), 32'h0);
      wait_clks(10 * TICK_CLKS - 2);
      rx_en = 1'b1;
      wait_clks(300);
      check("en_no_restart", 32'(busy), 32'h0);
      line = 1'b1;
      wait_clks(1000);
      check("en_no_done", 32'(done_cnt - base), 32'd0);
      check("en_out_hold", 32'(out), 32'h55);
      send_frame(8'hAA, 1'b1);
      check("en_aa_done_cnt", 32'(done_cnt - base), 32'd1);
      check("en_aa_out", 32'(out), 32'hAA);
      check("en_aa_err", 32'(err), 32'h0);

      wait_clks(100);
      check("no_double_done", 32'(dbl_done), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
